rca_word_collector: RTL and testbench

Downstream stage of the 4-bit ripple-carry adder; widens it to a `4*NIBBLES`-bit add. The upstream sequencer presents operand nibbles to the adder least-significant first, one per handshake. This block consumes each adder output (`s`, `co`) and applies the inter-nibble carry the adder cannot accept, since the adder has no carry-in. It assembles the full sum in a shift register and returns one word-sized result per `NIBBLES` accepted nibbles, with `cout`, over a valid/ready output handshake.

---
 rtl/rca_word_collector_pkg.sv | 20 ++
 rtl/rca_word_collector_nibble_inc.sv | 21 ++
 rtl/rca_word_collector.sv | 100 ++++++++++
 tb/tb_rca_word_collector.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rca_word_collector_pkg.sv
// Shared definitions for the ripple-carry word collector.
// Latency: n/a (constants, types and elaboration-time helpers only).
// Backpressure: n/a.
package rca_word_collector_pkg;

    // Width of one adder slice
    localparam int NIB_W = 4;

    // Collector control states
    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // Nibble counter width; a single-nibble word still needs a 1-bit counter
    function automatic int cnt_width(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/rca_word_collector_nibble_inc.sv
// Applies the inter-nibble carry to one adder result and merges the carries.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module nibble_inc
    import rca_word_collector_pkg::*;
(
    input  logic [NIB_W-1:0] s,
    input  logic             co,
    input  logic             c,
    output logic [NIB_W-1:0] r,
    output logic             c_next
);

    // Increment wraps at 4 bits; the adder carry and the increment overflow
    // never coincide, so an OR merges them without losing a carry.
    always_comb begin
        r      = s + {{(NIB_W-1){1'b0}}, c};
        c_next = co | (c & (s == {NIB_W{1'b1}}));
    end

endmodule

// File: rtl/rca_word_collector.sv
// Assembles NIBBLES ripple-carry adder nibbles (LS first) into one wide sum.
// Latency: out_valid rises one cycle after the last nibble accept.
// Backpressure: in_ready drops while a result is held; held until out_ready.
module rca_word_collector
    import rca_word_collector_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             s,
    input  logic                   co,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int W  = NIB_W * NIBBLES;
    localparam int CW = cnt_width(NIBBLES);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic [W-1:0]    shreg;
    logic [W-1:0]    shreg_nxt;
    logic [NIB_W-1:0] r;
    logic            c_next;
    logic            accept;
    logic            last_nib;
    logic            take;

    assign accept   = in_valid & in_ready;
    assign take     = out_valid & out_ready;
    assign last_nib = (cnt == CW'(NIBBLES - 1));

    nibble_inc u_inc (
        .s      (s),
        .co     (co),
        .c      (carry),
        .r      (r),
        .c_next (c_next)
    );

    // New nibble enters at the top so nibble 0 lands at [3:0] after a full word
    if (NIBBLES == 1) begin : g_single
        assign shreg_nxt = r;
    end else begin : g_multi
        assign shreg_nxt = {r, shreg[W-1:NIB_W]};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    // Next state: finish a word on the last accept, release it on handshake
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (accept && last_nib) state_nxt = HOLD;
            HOLD:    if (take)               state_nxt = COLLECT;
            default:                         state_nxt = COLLECT;
        endcase
    end

    // Handshake outputs decode the state register only, so both are registered
    always_comb begin
        in_ready  = (state == COLLECT);
        out_valid = (state == HOLD);
    end

    // Datapath: carry, counter and shift register advance only on an accept;
    // the result registers load on the word's final nibble and then stay put
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            carry <= 1'b0;
            shreg <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            shreg <= shreg_nxt;
            if (last_nib) begin
                cnt   <= '0;
                carry <= 1'b0;
                sum   <= shreg_nxt;
                cout  <= c_next;
            end else begin
                cnt   <= cnt + CW'(1);
                carry <= c_next;
            end
        end
    end

endmodule

// File: tb/tb_rca_word_collector.sv
module tb_rca_word_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // NIBBLES = 4 instance
    logic        in_valid, in_ready, co, cout, out_valid, out_ready;
    logic [3:0]  s;
    logic [15:0] sum;
    // NIBBLES = 1 instance
    logic        in_valid1, in_ready1, co1, cout1, out_valid1, out_ready1;
    logic [3:0]  s1;
    logic [3:0]  sum1;

    rca_word_collector #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .co(co), .sum(sum), .cout(cout),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    rca_word_collector #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .s(s1), .co(co1), .sum(sum1), .cout(cout1),
        .out_valid(out_valid1), .out_ready(out_ready1)
    );

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare whenever a result is handed over
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q4.size() == 0) begin
                tests++; fails++;
                $display("FAIL w4_unexpected: got sum 0x%0h with nothing expected", sum);
            end else begin
                e = q4.pop_front();
                chk("w4_sum", 32'(sum), 32'(e.sum));
                chk("w4_cout", 32'(cout), 32'(e.cout));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL w1_unexpected: got sum 0x%0h with nothing expected", sum1);
            end else begin
                e = q1.pop_front();
                chk("w1_sum", 32'(sum1), 32'(e.sum));
                chk("w1_cout", 32'(cout1), 32'(e.cout));
            end
        end
    end

    // Tasks start and end just after a rising edge
    task automatic send4(input logic [3:0] sv, input logic cv, input int gap);
        int n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1; s = sv; co = cv;
        @(negedge clk);
        while (!in_ready && n < 50) begin n++; @(negedge clk); end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0; s = 4'($urandom); co = 1'($urandom);
    endtask

    task automatic send_word(input logic [15:0] snib, input logic [3:0] cnib,
                             input logic [15:0] esum, input logic ecout, input bit gapped);
        q4.push_back('{sum: esum, cout: ecout});
        for (int i = 0; i < 4; i++)
            send4(snib[4*i +: 4], cnib[i], gapped ? i : 0);
        @(negedge clk);
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic send1(input logic [3:0] sv, input logic cv);
        int n = 0;
        q1.push_back('{sum: {12'h0, sv}, cout: cv});
        in_valid1 = 1'b1; s1 = sv; co1 = cv;
        @(negedge clk);
        while (!in_ready1 && n < 50) begin n++; @(negedge clk); end
        if (!in_ready1) begin
            tests++; fails++;
            $display("FAIL accept1_timeout: in_ready stayed 0, expected 1");
        end
        @(posedge clk); #1;
        in_valid1 = 1'b0; s1 = 4'($urandom); co1 = 1'($urandom);
        @(negedge clk);
        chk("w1_latency_out_valid", 32'(out_valid1), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; s = 4'h0; co = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; s1 = 4'h0; co1 = 1'b0; out_ready1 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst1_in_ready", 32'(in_ready1), 32'd1);
        chk("rst1_out_valid", 32'(out_valid1), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 0x1234 + 0x4321
        send_word(16'h5555, 4'b0000, 16'h5555, 1'b0, 1'b0);
        // 0xFFFF + 0x0001: carry rides through increment overflow
        send_word(16'hFFF0, 4'b0001, 16'h0000, 1'b1, 1'b0);
        // 0x8888 + 0x8888
        send_word(16'h0000, 4'b1111, 16'h1110, 1'b1, 1'b0);
        // 0xFFFF + 0x0001 with 1..3 idle cycles between nibbles
        send_word(16'hFFF0, 4'b0001, 16'h0000, 1'b1, 1'b1);

        // Backpressure: 0x0F0F + 0x0101 held for 5 cycles
        out_ready = 1'b0;
        send_word(16'h0000, 4'b0101, 16'h1010, 1'b0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", 32'(sum), 32'h1010);
            chk("bp_cout", 32'(cout), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        send_word(16'h0000, 4'b1111, 16'h1110, 1'b1, 1'b0);

        // Reset mid-word leaves a live carry and count behind if not cleared
        send4(4'h0, 1'b1, 0);
        send4(4'hF, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        send_word(16'h5555, 4'b0000, 16'h5555, 1'b0, 1'b0);

        // Single-nibble build is a registered pass-through
        send1(4'h7, 1'b1);
        send1(4'hF, 1'b0);
        send1(4'h0, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        chk("q4_drained", 32'(q4.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
